// File: rtl/scan_sel_ctrl.sv
// Scan select sequencer for a 2-to-4 active-low decoder: walks enabled slots with blanking gaps.
// Optional HOLD input (freezes the slot counter) is built when SCAN_HOLD_EN is defined.
module scan_sel_ctrl #(
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned BLANK    = 2,
    parameter int unsigned CW       = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EN,
    input  logic [3:0] MASK,
`ifdef SCAN_HOLD_EN
    input  logic       HOLD,
`endif
    output logic       A,
    output logic       B,
    output logic       G,
    output logic       SLOT_DONE,
    output logic       FRAME
);

    localparam logic [CW-1:0] PRE_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_ON
    } state_t;

    state_t          state_q, state_n;
    logic [1:0]      sel_q, sel_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic            g_q, g_n;
    logic            done_q, done_n;
    logic            frame_q, frame_n;
    logic            run;
    logic            hold;
    logic            frozen;

`ifdef SCAN_HOLD_EN
    assign hold = HOLD;
`else
    assign hold = 1'b0;
`endif

    function automatic logic [1:0] lowest_slot(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Circular search from s+1; falls back to s itself when it is the only enabled slot.
    function automatic logic [1:0] next_slot(input logic [3:0] m, input logic [1:0] s);
        logic [1:0] r;
        logic [1:0] c;
        r = s;
        for (int i = 3; i >= 1; i--) begin
            c = 2'(s + 2'(i));
            if (m[c]) r = c;
        end
        return r;
    endfunction

    function automatic logic any_above(input logic [3:0] m, input logic [1:0] s);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m[i] && (i > int'(s))) r = 1'b1;
        end
        return r;
    endfunction

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            g_q     <= 1'b1;
            done_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_n;
            sel_q   <= sel_n;
            cnt_q   <= cnt_n;
            g_q     <= g_n;
            done_q  <= done_n;
            frame_q <= frame_n;
        end
    end

    // Pulses are predicted one edge early so they appear registered on the last ON cycle.
    always_comb begin
        state_n = state_q;
        sel_n   = sel_q;
        cnt_n   = cnt_q;
        done_n  = 1'b0;
        frame_n = 1'b0;
        run     = EN && (MASK != 4'd0);
        frozen  = hold && (state_q != ST_IDLE);

        if (!run) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sel_n   = lowest_slot(MASK);
                    cnt_n   = '0;
                    state_n = (BLANK == 0) ? ST_ON : ST_BLANK;
                end
                ST_BLANK: begin
                    if (!frozen) begin
                        if (cnt_q == BLANK_LAST) begin
                            cnt_n   = '0;
                            state_n = ST_ON;
                        end else begin
                            cnt_n = cnt_q + CW'(1);
                        end
                    end
                end
                ST_ON: begin
                    // A hold released on the last count re-arms the pulse before advancing.
                    if (!frozen) begin
                        if (done_q) begin
                            sel_n   = next_slot(MASK, sel_q);
                            cnt_n   = '0;
                            state_n = (BLANK == 0) ? ST_ON : ST_BLANK;
                        end else if (cnt_q != PRE_LAST) begin
                            cnt_n = cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
            done_n  = (state_n == ST_ON) && !frozen && (cnt_n == PRE_LAST);
            frame_n = done_n && !any_above(MASK, sel_n);
        end
    end

    assign g_n       = (state_n != ST_ON);
    assign A         = sel_q[0];
    assign B         = sel_q[1];
    assign G         = g_q;
    assign SLOT_DONE = done_q;
    assign FRAME     = frame_q;

endmodule

// File: tb/tb_scan_sel_ctrl.sv
// Bench for scan_sel_ctrl: directed vector table, hand-written corner sequences,
// and randomized EN/MASK traffic checked against a slot-level reference model.
module tb_scan_sel_ctrl;

    localparam int P  = 4;
    localparam int BL = 1;

    logic       clk;
    logic       rst;
    logic       en1, en0, hold;
    logic [3:0] mask1, mask0;
    logic       a1, b1, g1, d1, f1;
    logic       a0, b0, g0, d0, f0;

    int checks   = 0;
    int failures = 0;

    scan_sel_ctrl #(.PRESCALE(P), .BLANK(BL), .CW(16)) u_dut (
        .CLK(clk), .RESET(rst), .EN(en1), .MASK(mask1),
`ifdef SCAN_HOLD_EN
        .HOLD(hold),
`endif
        .A(a1), .B(b1), .G(g1), .SLOT_DONE(d1), .FRAME(f1)
    );

    scan_sel_ctrl #(.PRESCALE(P), .BLANK(0), .CW(16)) u_dut0 (
        .CLK(clk), .RESET(rst), .EN(en0), .MASK(mask0),
`ifdef SCAN_HOLD_EN
        .HOLD(1'b0),
`endif
        .A(a0), .B(b0), .G(g0), .SLOT_DONE(d0), .FRAME(f0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: which phase we are in and how many cycles of it remain (including the current one).
    typedef struct {
        bit         act;
        bit         on;
        logic [1:0] sel;
        int         rem;
        logic [3:0] fm;
    } mst_t;

    typedef struct {
        bit         en;
        logic [3:0] mask;
        bit         g;
        logic [1:0] sel;
        bit         done;
        bit         frame;
    } vec_t;

    mst_t m1, m0;
    vec_t tbl[22];

    function automatic mst_t mreset();
        mst_t n;
        n.act = 0; n.on = 0; n.sel = 2'd0; n.rem = 0; n.fm = 4'd0;
        return n;
    endfunction

    function automatic mst_t mstep(input mst_t s, input bit en, input logic [3:0] m,
                                   input int p, input int bl);
        mst_t n;
        n = s;
        n.fm = m;
        if (!en || m == 4'd0) begin
            n.act = 0; n.on = 0; n.rem = 0;
        end else if (!s.act) begin
            n.act = 1;
            for (int i = 3; i >= 0; i--) if (m[i]) n.sel = 2'(i);
            n.on  = (bl == 0);
            n.rem = (bl == 0) ? p : bl;
        end else if (!s.on) begin
            if (s.rem == 1) begin n.on = 1; n.rem = p; end
            else n.rem = s.rem - 1;
        end else if (s.rem == 1) begin
            for (int k = 4; k >= 1; k--) if (m[(int'(s.sel) + k) % 4]) n.sel = 2'((int'(s.sel) + k) % 4);
            n.on  = (bl == 0);
            n.rem = (bl == 0) ? p : bl;
        end else begin
            n.rem = s.rem - 1;
        end
        return n;
    endfunction

    function automatic bit exp_done(input mst_t s);
        return s.act && s.on && (s.rem == 1);
    endfunction

    function automatic bit exp_frame(input mst_t s);
        return exp_done(s) && ((int'(s.fm) >> (int'(s.sel) + 1)) == 0);
    endfunction

    function automatic vec_t row(input bit en, input logic [3:0] m, input bit g,
                                 input logic [1:0] sel, input bit done, input bit frame);
        vec_t v;
        v.en = en; v.mask = m; v.g = g; v.sel = sel; v.done = done; v.frame = frame;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cmp_models();
        chk("m1_g", 8'(g1), 8'(!(m1.act && m1.on)));
        chk("m1_sel", 8'({b1, a1}), 8'(m1.sel));
        chk("m1_done", 8'(d1), 8'(exp_done(m1)));
        chk("m1_frame", 8'(f1), 8'(exp_frame(m1)));
        chk("m0_g", 8'(g0), 8'(!(m0.act && m0.on)));
        chk("m0_sel", 8'({b0, a0}), 8'(m0.sel));
        chk("m0_done", 8'(d0), 8'(exp_done(m0)));
        chk("m0_frame", 8'(f0), 8'(exp_frame(m0)));
    endtask

    task automatic tick();
        @(posedge clk);
        m1 = mstep(m1, en1, mask1, P, BL);
        m0 = mstep(m0, en0, mask0, P, 0);
        @(negedge clk);
        cmp_models();
    endtask

    initial begin
        int guard;

        tbl[0]  = row(1, 4'hF, 1, 2'd0, 0, 0);
        tbl[1]  = row(1, 4'hF, 0, 2'd0, 0, 0);
        tbl[2]  = row(1, 4'hF, 0, 2'd0, 0, 0);
        tbl[3]  = row(1, 4'hF, 0, 2'd0, 0, 0);
        tbl[4]  = row(1, 4'hF, 0, 2'd0, 1, 0);
        tbl[5]  = row(1, 4'hF, 1, 2'd1, 0, 0);
        tbl[6]  = row(1, 4'hF, 0, 2'd1, 0, 0);
        tbl[7]  = row(1, 4'hF, 0, 2'd1, 0, 0);
        tbl[8]  = row(1, 4'hF, 0, 2'd1, 0, 0);
        tbl[9]  = row(1, 4'hF, 0, 2'd1, 1, 0);
        tbl[10] = row(1, 4'hF, 1, 2'd2, 0, 0);
        tbl[11] = row(1, 4'hF, 0, 2'd2, 0, 0);
        tbl[12] = row(1, 4'hF, 0, 2'd2, 0, 0);
        tbl[13] = row(1, 4'hF, 0, 2'd2, 0, 0);
        tbl[14] = row(1, 4'hF, 0, 2'd2, 1, 0);
        tbl[15] = row(1, 4'hF, 1, 2'd3, 0, 0);
        tbl[16] = row(1, 4'hF, 0, 2'd3, 0, 0);
        tbl[17] = row(1, 4'hF, 0, 2'd3, 0, 0);
        tbl[18] = row(1, 4'hF, 0, 2'd3, 0, 0);
        tbl[19] = row(1, 4'hF, 0, 2'd3, 1, 1);
        tbl[20] = row(1, 4'hF, 1, 2'd0, 0, 0);
        tbl[21] = row(1, 4'hF, 0, 2'd0, 0, 0);

        rst = 1'b1; en1 = 1'b0; en0 = 1'b0; mask1 = 4'd0; mask0 = 4'd0; hold = 1'b0;
        m1 = mreset(); m0 = mreset();
        repeat (2) @(negedge clk);
        chk("rst_g", 8'(g1), 8'd1);
        chk("rst_ab", 8'({b1, a1}), 8'd0);
        chk("rst_done", 8'(d1), 8'd0);
        chk("rst_frame", 8'(f1), 8'd0);
        chk("rst_g0", 8'(g0), 8'd1);
        rst = 1'b0;

        // Basic full-mask walk through all four slots.
        for (int i = 0; i < 22; i++) begin
            en1 = tbl[i].en; mask1 = tbl[i].mask;
            tick();
            chk($sformatf("tbl%0d_g", i), 8'(g1), 8'(tbl[i].g));
            chk($sformatf("tbl%0d_sel", i), 8'({b1, a1}), 8'(tbl[i].sel));
            chk($sformatf("tbl%0d_done", i), 8'(d1), 8'(tbl[i].done));
            chk($sformatf("tbl%0d_frame", i), 8'(f1), 8'(tbl[i].frame));
        end

        // Disable during cycle 3 of slot 1, then re-enable.
        en1 = 1'b0; tick();
        en1 = 1'b1; mask1 = 4'hF;
        repeat (9) tick();
        chk("dis_pre_sel", 8'({b1, a1}), 8'd1);
        chk("dis_pre_g", 8'(g1), 8'd0);
        en1 = 1'b0; tick();
        chk("dis_g", 8'(g1), 8'd1);
        chk("dis_sel_kept", 8'({b1, a1}), 8'd1);
        chk("dis_done", 8'(d1), 8'd0);
        en1 = 1'b1; tick();
        chk("reen_blank_g", 8'(g1), 8'd1);
        chk("reen_sel", 8'({b1, a1}), 8'd0);
        tick();
        chk("reen_on_g", 8'(g1), 8'd0);
        chk("reen_on_sel", 8'({b1, a1}), 8'd0);

        // Sparse mask: only slots 1 and 3 may be driven.
        en1 = 1'b0; tick();
        en1 = 1'b1; mask1 = 4'b1010;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (!g1) chk("mask_on_odd", 8'(a1), 8'd1);
            if (f1) chk("mask_frame_sel", 8'({b1, a1}), 8'd3);
        end

        // Single slot with no blanking on the BLANK=0 instance.
        en0 = 1'b1; mask0 = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("single_g", 8'(g0), 8'd0);
            chk("single_sel", 8'({b0, a0}), 8'd2);
            chk("single_done", 8'(d0), 8'((i % 4) == 3));
            chk("single_frame", 8'(f0), 8'((i % 4) == 3));
        end
        en0 = 1'b0; tick();

        // Asynchronous reset landing on a last-ON cycle, between edges.
        en1 = 1'b1; mask1 = 4'hF;
        guard = 0;
        while (!exp_done(m1) && guard < 30) begin tick(); guard++; end
        chk("ar_reached_done", 8'(d1), 8'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_g", 8'(g1), 8'd1);
        chk("ar_ab", 8'({b1, a1}), 8'd0);
        chk("ar_done", 8'(d1), 8'd0);
        chk("ar_frame", 8'(f1), 8'd0);
        m1 = mreset(); m0 = mreset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < BL; i++) begin
            tick();
            chk("ar_blank_g", 8'(g1), 8'd1);
        end
        tick();
        chk("ar_first_on", 8'(g1), 8'd0);

        // Randomized EN/MASK traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            en1 = ($urandom_range(0, 15) != 0);
            en0 = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 9) == 0) mask1 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) mask0 = 4'($urandom_range(0, 15));
            tick();
        end

`ifdef SCAN_HOLD_EN
        // HOLD freezes slot 0 mid-count; EN on u_dut0 stays low so it idles.
        en0 = 1'b0;
        en1 = 1'b0; @(posedge clk); @(negedge clk);
        en1 = 1'b1; mask1 = 4'hF;
        repeat (BL + 2) begin @(posedge clk); @(negedge clk); end
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            chk("hold_g", 8'(g1), 8'd0);
            chk("hold_sel", 8'({b1, a1}), 8'd0);
            chk("hold_done", 8'(d1), 8'd0);
        end
        hold = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("hold_rel1_done", 8'(d1), 8'd0);
        @(posedge clk); @(negedge clk);
        chk("hold_rel2_done", 8'(d1), 8'd1);
        chk("hold_rel2_g", 8'(g1), 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
